sipo_frame_rx: RTL
==================

Name: sipo_frame_rx

Overview:
- Serial-to-parallel framed receiver: the far end of the single-bit serial line our shift-register chains drive.
- Samples `sin` once per `clk` rising edge and detects a start bit.
- Deserialises WIDTH data bits plus an optional even-parity bit, then checks the stop bit.
- Presents the word on a valid/ready parallel port, with framing, parity and overrun error pulses.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- PARITY_EN, 1, 1 = one even-parity bit follows the data; 0 = no parity bit.
- MSB_FIRST, 1, 1 = first data bit received is dout[WIDTH-1]; 0 = first is dout[0].

Ports:
- clk  input  1  sole clock; all sampling on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- sin  input  1  serial line; idle level 0, start bit 1, stop bit 0.
- dout  output  WIDTH  received word; stable while dout_valid=1.
- dout_valid  output  1  word available; held until accepted.
- dout_ready  input  1  consumer accepts; a transfer occurs on a rising edge with valid&ready.
- busy  output  1  1 whenever the FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
- parity_err  output  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only).
- overrun  output  1  one-cycle pulse: a good frame was dropped because the output was still occupied.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register, bit counter, dout and all outputs = 0.
  - A mid-frame reset aborts the frame and clears any pending dout_valid.
  - No pulses are generated on reset release.
- Frame format: 1 start + WIDTH data + PARITY_EN parity + 1 stop, one bit per clock. No oversampling; the line is synchronous to clk.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: sin=1 at an edge goes to DATA with cnt=0; sin=0 stays in IDLE.
  - DATA: shifts sin into the shift register (direction per MSB_FIRST) and increments cnt. The edge where cnt==WIDTH-1 goes to PARITY if PARITY_EN, else to STOP.
  - PARITY: captures sin into p_bit, then goes to STOP.
  - STOP: samples sin, evaluates the frame and always returns to IDLE. A new start bit is accepted on the very next edge, so back-to-back frames have zero idle gap.
- Frame evaluation (on the STOP edge):
  - ferr = (sin==1).
  - perr = PARITY_EN & (^data ^ p_bit).
  - frame_err and parity_err pulse high for the cycle after that edge, independently; both may pulse together.
  - If ferr or perr, the frame is discarded and dout/dout_valid are untouched.
  - A stop bit of 1 is never reinterpreted as a start bit.
- Commit (good frame):
  - If dout_valid==0, or dout_valid&dout_ready on the same edge: dout <= data and dout_valid <= 1 on that STOP edge.
  - Otherwise the new frame is dropped, overrun pulses for 1 cycle, and the old dout/dout_valid are kept.
- Latency: with the start bit sampled at edge 0, dout_valid rises after edge WIDTH+1+PARITY_EN (edge 10 for the defaults).
- Handshake:
  - dout_valid deasserts on the edge where dout_ready=1, unless a commit happens on that same edge, in which case it stays 1 and carries the new dout.
  - dout_ready while dout_valid=0 has no effect.
  - dout never changes while dout_valid=1 except through an accept+commit.
- Outputs are registered; no combinational path from sin or dout_ready to any output.
- busy=1 in DATA, PARITY and STOP.
- Counter width: $clog2(WIDTH).

Decomposition:
- Shared package `serial_pkg`:
  - state enum `rx_state_t` {IDLE, DATA, PARITY, STOP};
  - constants START_BIT=1, STOP_BIT=0, IDLE_LVL=0;
  - function `frame_len(width, par_en)`;
  - function `even_parity(data)`.
  - The package is reused by the matching transmitter.
- One sub-module is natural: `sipo_shift_core`, a WIDTH-bit shift register with shift-enable, clear and MSB_FIRST direction. The FSM, counter, checks and handshake stay in the top module.

Test Plan (all with WIDTH=8, PARITY_EN=1, MSB_FIRST=1):
1. Reset then idle: rst=0 mid-frame, release, sin=0 for 20 cycles -> all outputs 0, busy=0, no pulses.
2. Good frame: bits 1,1,0,1,0,0,1,0,1,0(par),0(stop), dout_ready=1 -> dout=8'hA5 and dout_valid=1 after edge 10; dout_valid=0 the next cycle; busy=1 for edges 0-9.
3. Back-to-back frames with dout_ready=0: 0xA5 then 0x3C with no gap -> dout stays 8'hA5, valid held, overrun pulses once at the second stop edge. Then ready=1 -> valid drops after one accept.
4. Framing error: 0x5A frame with stop=1 -> frame_err 1-cycle pulse, dout_valid stays 0, FSM in IDLE. A following good 0x01 frame is received correctly.
5. Parity error: 0xA5 with parity bit 1 -> parity_err pulse, frame discarded. Stop=1 in the same frame -> frame_err and parity_err pulse together.
6. Simultaneous accept and commit: dout_valid=1 (0x11) with dout_ready=1 on the stop edge of 0x22 -> dout=8'h22, valid stays 1, no overrun. Also run with MSB_FIRST=0: serial 1,0,0,0,0,0,0,0 -> dout=8'h01.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial link (receiver and matching transmitter).
// Contents:
//   rx_state_t  - frame FSM states
//   START_BIT, STOP_BIT, IDLE_LVL - line levels of the frame format
//   frame_len() - total bits per frame including start and stop
//   even_parity() - parity bit that makes the count of ones even
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  function automatic int unsigned frame_len(input int unsigned width, input bit par_en);
    return 32'd2 + width + (par_en ? 32'd1 : 32'd0);
  endfunction

  // Zero-extension of narrower words does not change the result.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in parallel-out shift register.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - synchronous clear (has priority over shift_en)
//   shift_en  - shift sin in on this edge
//   sin       - serial input bit
//   data      - parallel contents; with MSB_FIRST the first bit shifted in
//               ends up in data[WIDTH-1], otherwise in data[0]
module sipo_shift_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_r;

  // Shift register: clear, or shift one bit in from the chosen end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= '0;
    end else if (clr) begin
      data_r <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        data_r <= {data_r[WIDTH-2:0], sin};
      end else begin
        data_r <= {sin, data_r[WIDTH-1:1]};
      end
    end
  end

  assign data = data_r;

endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial-to-parallel receiver.
// Frame: start(1) + WIDTH data + optional even parity + stop(0), one bit per clk.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   sin         - serial line (idle 0)
//   dout        - received word, stable while dout_valid=1
//   dout_valid  - word available, held until accepted
//   dout_ready  - consumer accept (transfer on valid&ready at a rising edge)
//   busy        - a frame is in progress
//   frame_err   - one-cycle pulse: stop bit was 1
//   parity_err  - one-cycle pulse: parity mismatch
//   overrun     - one-cycle pulse: good frame dropped, output still occupied
module sipo_frame_rx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  rx_state_t        state_r;
  rx_state_t        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             p_bit_r;
  logic [WIDTH-1:0] data_s;
  logic             shift_en_s;
  logic             clr_s;
  logic             stop_edge_s;
  logic             ferr_s;
  logic             perr_s;
  logic             good_s;
  logic             accept_s;
  logic             commit_s;

  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             busy_r;
  logic             frame_err_r;
  logic             parity_err_r;
  logic             overrun_r;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST != 0)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .shift_en (shift_en_s),
    .sin      (sin),
    .data     (data_s)
  );

  // Next-state decode, shift control and stop-edge frame evaluation.
  always_comb begin
    state_nxt_s = state_r;
    shift_en_s  = 1'b0;
    clr_s       = 1'b0;
    stop_edge_s = 1'b0;
    ferr_s      = 1'b0;
    perr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (sin == START_BIT) begin
          state_nxt_s = DATA;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        shift_en_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          if (PARITY_EN != 0) begin
            state_nxt_s = PARITY;
          end else begin
            state_nxt_s = STOP;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        state_nxt_s = STOP;
      end
      STOP: begin
        // Always back to IDLE: a bad stop bit of 1 must not start a frame.
        state_nxt_s = IDLE;
        stop_edge_s = 1'b1;
        ferr_s      = (sin != STOP_BIT);
        perr_s      = (PARITY_EN != 0) && (even_parity(32'(data_s)) != p_bit_r);
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    good_s   = stop_edge_s && !ferr_s && !perr_s;
    accept_s = dout_valid_r && dout_ready;
    // A same-edge accept frees the slot for the incoming word.
    commit_s = good_s && (!dout_valid_r || dout_ready);
  end

  // FSM state, data bit counter and captured parity bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      p_bit_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      case (state_r)
        DATA:    cnt_r <= cnt_r + CNT_W'(1);
        PARITY: begin
          cnt_r   <= '0;
          p_bit_r <= sin;
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  // Output word, valid/ready handshake and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_err_r  <= ferr_s;
      parity_err_r <= perr_s;
      overrun_r    <= good_s && !commit_s;
      if (commit_s) begin
        dout_r       <= data_s;
        dout_valid_r <= 1'b1;
      end else if (accept_s) begin
        dout_valid_r <= 1'b0;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign overrun    = overrun_r;

endmodule
